// File: rtl/branch_update_unit_pkg.sv
// Shared definitions for the branch update path: entry layout, PC step and the
// 2-bit saturating counter encodings also used by the predictor.
package branch_update_unit_pkg;

    localparam int          BR_ENTRY_W = 33;
    localparam logic [31:0] BR_PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        BR_CTR_SNT = 2'b00,
        BR_CTR_WNT = 2'b01,
        BR_CTR_WT  = 2'b10,
        BR_CTR_ST  = 2'b11
    } br_ctr_e;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
    } br_entry_t;

    function automatic logic [31:0] br_fallthrough(input logic [31:0] pc);
        return pc + BR_PC_STEP;
    endfunction

endpackage

// File: rtl/branch_update_unit_sync_fifo.sv
// Small synchronous FIFO with a combinational head read and an occupancy count.
// The caller guarantees no push when full and no pop when empty.
module sync_fifo #(
    parameter int WIDTH     = 33,
    parameter int DEPTH_LOG = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic                 pop,
    input  logic [WIDTH-1:0]     din,
    output logic [WIDTH-1:0]     dout,
    output logic [DEPTH_LOG:0]   count
);
    localparam int DEPTH = 1 << DEPTH_LOG;

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [DEPTH_LOG-1:0] wr_ptr_q;
    logic [DEPTH_LOG-1:0] rd_ptr_q;
    logic [DEPTH_LOG:0]   count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: only entries covered by count are ever read.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/branch_update_unit.sv
// Commit-side producer for the branch predictor update port plus mispredict redirect.
// Optional statistics counters are built only when BRANCH_STATS_EN is defined.
module branch_update_unit
    import branch_update_unit_pkg::*;
#(
    parameter int DEPTH_LOG = 2
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic        commit_valid,
    output logic        commit_ready,
    input  logic [31:0] commit_PC,
    input  logic        commit_taken,
    input  logic        commit_pred,
    input  logic [31:0] commit_target,
    output logic        update_en,
    output logic [31:0] update_PC,
    output logic        update_result,
    output logic        mispredict_en,
    output logic [31:0] mispredict_PC,
    output logic [31:0] stat_branch_cnt,
    output logic [31:0] stat_miss_cnt
);
    localparam int                 DEPTH    = 1 << DEPTH_LOG;
    localparam logic [DEPTH_LOG:0] FULL_CNT = (DEPTH_LOG + 1)'(DEPTH);

    logic [DEPTH_LOG:0]  fifo_count;
    logic [BR_ENTRY_W-1:0] push_bits;
    logic [BR_ENTRY_W-1:0] head_bits;
    br_entry_t           head;
    logic                push;
    logic                pop;
    logic                miss;

    logic        update_en_q,     update_en_d;
    logic [31:0] update_pc_q,     update_pc_d;
    logic        update_result_q, update_result_d;
    logic        mis_en_q,        mis_en_d;
    logic [31:0] mis_pc_q,        mis_pc_d;

    assign commit_ready = rdy_in && (fifo_count != FULL_CNT);
    assign push         = commit_valid && commit_ready;
    assign pop          = rdy_in && (fifo_count != '0);
    assign miss         = commit_taken != commit_pred;
    assign push_bits    = {commit_PC, commit_taken};
    assign head         = head_bits;

    sync_fifo #(
        .WIDTH     (BR_ENTRY_W),
        .DEPTH_LOG (DEPTH_LOG)
    ) u_fifo (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .push  (push),
        .pop   (pop),
        .din   (push_bits),
        .dout  (head_bits),
        .count (fifo_count)
    );

    // While paused every register holds, including the strobes.
    always_comb begin
        update_en_d     = update_en_q;
        update_pc_d     = update_pc_q;
        update_result_d = update_result_q;
        mis_en_d        = mis_en_q;
        mis_pc_d        = mis_pc_q;
        if (rdy_in) begin
            update_en_d = pop;
            if (pop) begin
                update_pc_d     = head.pc;
                update_result_d = head.taken;
            end
            mis_en_d = push && miss;
            if (push && miss) begin
                mis_pc_d = commit_taken ? commit_target : br_fallthrough(commit_PC);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            update_en_q     <= 1'b0;
            update_pc_q     <= '0;
            update_result_q <= 1'b0;
            mis_en_q        <= 1'b0;
            mis_pc_q        <= '0;
        end else begin
            update_en_q     <= update_en_d;
            update_pc_q     <= update_pc_d;
            update_result_q <= update_result_d;
            mis_en_q        <= mis_en_d;
            mis_pc_q        <= mis_pc_d;
        end
    end

    assign update_en     = update_en_q;
    assign update_PC     = update_pc_q;
    assign update_result = update_result_q;
    assign mispredict_en = mis_en_q;
    assign mispredict_PC = mis_pc_q;

`ifdef BRANCH_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [31:0] br_cnt_q,   br_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    // push already implies rdy_in, so the counters freeze while paused.
    always_comb begin
        br_cnt_d   = br_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (push)         br_cnt_d   = sat_inc(br_cnt_q);
        if (push && miss) miss_cnt_d = sat_inc(miss_cnt_q);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            br_cnt_q   <= '0;
            miss_cnt_q <= '0;
        end else begin
            br_cnt_q   <= br_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign stat_branch_cnt = br_cnt_q;
    assign stat_miss_cnt   = miss_cnt_q;
`else
    assign stat_branch_cnt = 32'd0;
    assign stat_miss_cnt   = 32'd0;
`endif

endmodule
